// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one Sub_adder_16bit among NREQ requesters.
// Optional signed-overflow output enabled by `define ADDSUB_ARB_OVF_EN.

module Sub_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  output logic [15:0] sum,
  output logic        cout
);
  // mode=1 turns B into its two's complement: A + ~B + 1
  assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {16{mode}}} + {16'd0, mode};
endmodule

module addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][15:0] req_a,
  input  logic [NREQ-1:0][15:0] req_b,
  input  logic [NREQ-1:0]       req_mode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           rsp_sum,
  output logic                  rsp_cout
`ifdef ADDSUB_ARB_OVF_EN
  , output logic                rsp_ovf
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     st;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic [15:0]    op_a, op_b;
  logic           op_mode;
  logic [IDW-1:0] op_id;
  logic [15:0]    alu_sum;
  logic           alu_cout;
  logic           grant_ok;

  // Rotating search: first valid requester after ptr, wrapping.
  always_comb begin
    logic [IDW:0] j;
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = {1'b0, ptr} + (IDW+1)'(i);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (!found && req_valid[j[IDW-1:0]]) begin
        found = 1'b1;
        win   = j[IDW-1:0];
      end
    end
  end

  // rst_n gating keeps req_ready low for the whole reset interval.
  assign grant_ok = (st == S_IDLE) && found && rst_n;

  for (genvar k = 0; k < NREQ; k++) begin : g_rdy
    assign req_ready[k] = grant_ok && (win == IDW'(k));
  end

  Sub_adder_16bit u_alu (
    .a    (op_a),
    .b    (op_b),
    .mode (op_mode),
    .sum  (alu_sum),
    .cout (alu_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      ptr       <= IDW'(NREQ-1);
      op_a      <= '0;
      op_b      <= '0;
      op_mode   <= 1'b0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (grant_ok) begin
          op_a    <= req_a[win];
          op_b    <= req_b[win];
          op_mode <= req_mode[win];
          op_id   <= win;
          ptr     <= win;
          st      <= S_EXEC;
        end
        S_EXEC: begin
          rsp_sum   <= alu_sum;
          rsp_cout  <= alu_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          st        <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          st        <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef ADDSUB_ARB_OVF_EN
  // Effective B sign is b15^mode; overflow when result sign differs from equal input signs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rsp_ovf <= 1'b0;
    else if (st == S_EXEC) rsp_ovf <= (op_a[15] == (op_b[15] ^ op_mode)) && (alu_sum[15] != op_a[15]);
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter; overflow vectors run when ADDSUB_ARB_OVF_EN is defined.

module tb_addsub_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready, req_mode;
  logic [NREQ-1:0][15:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           rsp_sum;
  logic                  rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
  logic                  rsp_ovf;
  logic                  last_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  addsub_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDSUB_ARB_OVF_EN
    , .rsp_ovf (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 8) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  // Single transaction on requester k with rsp_ready high; called at a negedge.
  task automatic txn(input int k, input logic [15:0] a, input logic [15:0] b, input logic m,
                     input logic [15:0] es, input logic ec);
    req_a[k] = a; req_b[k] = b; req_mode[k] = m;
    req_valid = '0; req_valid[k] = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("grant", {28'd0, req_ready}, 32'd1 << k);
    @(posedge clk); @(negedge clk); #1;
    chk("exec_ready", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    wait_rsp();
    chk("rsp_id", {30'd0, rsp_id}, k);
    chk("rsp_sum", {16'd0, rsp_sum}, {16'd0, es});
    chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, ec});
`ifdef ADDSUB_ARB_OVF_EN
    last_ovf = rsp_ovf;
`endif
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int exp_id [6] = '{0, 1, 2, 3, 0, 1};
    int ng, nr, last;

    rst_n = 1'b0; req_valid = 4'b0001; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_mode = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_id",    {30'd0, rsp_id},    32'd0);
    chk("rst_sum",   {16'd0, rsp_sum},   32'd0);
    chk("rst_cout",  {31'd0, rsp_cout},  32'd0);
`ifdef ADDSUB_ARB_OVF_EN
    chk("rst_ovf",   {31'd0, rsp_ovf},   32'd0);
`endif
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic arithmetic
    txn(0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0);
    txn(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    txn(2, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);
    txn(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);

    // Round robin from reset, all requesters valid
    rst_n = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k] = 16'(k * 16'h0101); req_b[k] = 16'h0000; req_mode[k] = 1'b0;
    end
    req_valid = '1; rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    ng = 0; nr = 0; last = 0;
    for (int cyc = 0; cyc < 40 && nr < 6; cyc++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
        if (ng > 0 && ng < 6) chk("rr_gap", cyc - last, 32'd3);
        last = cyc; ng++;
      end
      if (rsp_valid) begin
        chk("rr_id", {30'd0, rsp_id}, exp_id[nr]);
        chk("rr_sum", {16'd0, rsp_sum}, exp_id[nr] * 32'h0101);
        nr++;
      end
      if (nr < 6) @(negedge clk);
    end
    chk("rr_count", nr, 32'd6);
    req_valid = '0;
    @(posedge clk); @(negedge clk);

    // Back-pressure with req1 pending
    rsp_ready = 1'b0;
    req_a[0] = 16'h0100; req_b[0] = 16'h0023; req_mode[0] = 1'b0;
    req_valid = 4'b0001;
    #1 chk("bp_grant0", {28'd0, req_ready}, 32'b0001);
    @(posedge clk); @(negedge clk);
    req_a[1] = 16'h00FF; req_b[1] = 16'h0001; req_mode[1] = 1'b0;
    req_valid = 4'b0010;
    #1;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_id",    {30'd0, rsp_id},    32'd0);
      chk("bp_sum",   {16'd0, rsp_sum},   32'h0123);
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("bp_after_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_grant1", {28'd0, req_ready}, 32'b0010);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp();
    chk("bp_id1",  {30'd0, rsp_id},  32'd1);
    chk("bp_sum1", {16'd0, rsp_sum}, 32'h0100);
    @(posedge clk); @(negedge clk);

    // Reset during EXEC of a req3 transaction
    req_a[3] = 16'h1111; req_b[3] = 16'h2222; req_mode[3] = 1'b0;
    req_a[0] = 16'h0010; req_b[0] = 16'h0020; req_mode[0] = 1'b0;
    req_valid = 4'b1000;
    #1 chk("rx_grant3", {28'd0, req_ready}, 32'b1000);
    @(posedge clk); @(negedge clk);
    req_valid = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("rx_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rx_ready", {28'd0, req_ready}, 32'd0);
    chk("rx_sum",   {16'd0, rsp_sum},   32'd0);
    @(negedge clk); #1;
    chk("rx_valid2", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rx_first0", {28'd0, req_ready}, 32'b0001);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    #1;
    wait_rsp();
    chk("rx_id",  {30'd0, rsp_id},  32'd0);
    chk("rx_sum0", {16'd0, rsp_sum}, 32'h0030);
    @(posedge clk); @(negedge clk);

`ifdef ADDSUB_ARB_OVF_EN
    txn(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
    chk("ovf_add", {31'd0, last_ovf}, 32'd1);
    txn(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
    chk("ovf_sub", {31'd0, last_ovf}, 32'd1);
    txn(1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    chk("ovf_none", {31'd0, last_ovf}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
